// File: rtl/alu_dec_if.sv
// Handshake and decoded-field bundle between the instruction source, the
// alu_dec decoder and the ALU/execute stage.
interface alu_dec_if;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic        alu_valid;
   logic        alu_ready;
   logic [3:0]  alu_decode;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [4:0]  rd_addr;
   logic        imm_sel;
   logic [31:0] imm;
   logic        illegal;
   logic [7:0]  illegal_cnt;

   modport master (
      output instr_valid, instr, alu_ready,
      input  instr_ready, alu_valid, alu_decode, rs1_addr, rs2_addr, rd_addr,
             imm_sel, imm, illegal, illegal_cnt
   );

   modport slave (
      input  instr_valid, instr, alu_ready,
      output instr_ready, alu_valid, alu_decode, rs1_addr, rs2_addr, rd_addr,
             imm_sel, imm, illegal, illegal_cnt
   );
endinterface

// File: rtl/alu_dec.sv
// Two-stage RV32 ALU decoder (S1 raw instruction, S2 decoded fields).
// Optional I-type immediate decode enabled by macro ALU_DEC_IMM_EN.
module alu_dec (
   input logic     clk,
   input logic     reset,
   alu_dec_if.slave bus
);
   localparam int unsigned IW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned OPW = 4;
   localparam int unsigned CW = 8;

   localparam logic [6:0] OPC_R = 7'b0110011;
   localparam logic [6:0] OPC_I = 7'b0010011;
   localparam logic [OPW-1:0] OP_ILL = 4'hF;
   localparam logic [CW-1:0] CNT_MAX = 8'hFF;

   typedef struct packed {
      logic [OPW-1:0] op;
      logic [AW-1:0]  rs1;
      logic [AW-1:0]  rs2;
      logic [AW-1:0]  rd;
      logic           imm_sel;
      logic           illegal;
   } dec_t;

   logic          s1_valid;
   logic [IW-1:0] s1_instr;
   logic          s2_valid;
   dec_t          s2_dec;
   dec_t          d_c;
   logic [CW-1:0] cnt;
   logic          s2_adv_c;
   logic          s1_adv_c;
   logic          accept_c;
   logic          deliver_c;

   logic [6:0] opcode_c;
   logic [2:0] funct3_c;
   logic [6:0] funct7_c;

   assign opcode_c = s1_instr[6:0];
   assign funct3_c = s1_instr[14:12];
   assign funct7_c = s1_instr[31:25];

   // Stage advance: S2 moves when empty or delivering, S1 when empty or S2 moves.
   assign s2_adv_c    = !s2_valid || bus.alu_ready;
   assign s1_adv_c    = !s1_valid || s2_adv_c;
   assign bus.instr_ready = reset && s1_adv_c;
   assign accept_c    = bus.instr_valid && bus.instr_ready;
   assign deliver_c   = s2_valid && bus.alu_ready;

`ifdef ALU_DEC_IMM_EN
   logic [IW-1:0] d_imm_c;
   logic [IW-1:0] s2_imm;
`endif

   // Decode of the instruction held in S1.
   always_comb begin
      d_c         = '0;
      d_c.op      = OP_ILL;
      d_c.illegal = 1'b1;
      d_c.rs1     = s1_instr[19:15];
      d_c.rs2     = s1_instr[24:20];
      d_c.rd      = s1_instr[11:7];
`ifdef ALU_DEC_IMM_EN
      d_imm_c     = '0;
`endif
      if (opcode_c == OPC_R) begin
         d_c.illegal = 1'b0;
         unique case ({funct7_c, funct3_c})
            10'b0000000_000: d_c.op = 4'd2;
            10'b0100000_000: d_c.op = 4'd6;
            10'b0000000_001: d_c.op = 4'd3;
            10'b0000000_010: d_c.op = 4'd4;
            10'b0000000_011: d_c.op = 4'd5;
            10'b0000000_100: d_c.op = 4'd7;
            10'b0100000_101: d_c.op = 4'd8;
            10'b0000000_110: d_c.op = 4'd1;
            10'b0000000_111: d_c.op = 4'd0;
            default: begin
               d_c.op      = OP_ILL;
               d_c.illegal = 1'b1;
            end
         endcase
      end
`ifdef ALU_DEC_IMM_EN
      else if (opcode_c == OPC_I) begin
         d_c.illegal = 1'b0;
         d_imm_c     = {{20{s1_instr[31]}}, s1_instr[31:20]};
         unique case (funct3_c)
            3'b000: d_c.op = 4'd2;
            3'b010: d_c.op = 4'd4;
            3'b011: d_c.op = 4'd5;
            3'b100: d_c.op = 4'd7;
            3'b110: d_c.op = 4'd1;
            3'b111: d_c.op = 4'd0;
            3'b001: begin
               d_c.op      = (funct7_c == 7'b0000000) ? 4'd3 : OP_ILL;
               d_c.illegal = (funct7_c != 7'b0000000);
               d_imm_c     = IW'(s1_instr[24:20]);
            end
            3'b101: begin
               d_c.op      = (funct7_c == 7'b0100000) ? 4'd8 : OP_ILL;
               d_c.illegal = (funct7_c != 7'b0100000);
               d_imm_c     = IW'(s1_instr[24:20]);
            end
            default: begin
               d_c.op      = OP_ILL;
               d_c.illegal = 1'b1;
            end
         endcase
         if (d_c.illegal) begin
            d_imm_c = '0;
         end else begin
            d_c.imm_sel = 1'b1;
            d_c.rs2     = '0;
         end
      end
`endif
   end

   // Pipeline registers and saturating illegal-beat counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_instr <= '0;
         s2_valid <= 1'b0;
         s2_dec   <= '0;
         cnt      <= '0;
`ifdef ALU_DEC_IMM_EN
         s2_imm   <= '0;
`endif
      end else begin
         if (s1_adv_c) begin
            s1_valid <= accept_c;
            if (accept_c) begin
               s1_instr <= bus.instr;
            end
         end
         if (s2_adv_c) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_dec <= d_c;
`ifdef ALU_DEC_IMM_EN
               s2_imm <= d_imm_c;
`endif
            end
         end
         if (deliver_c && s2_dec.illegal && (cnt != CNT_MAX)) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign bus.alu_valid   = s2_valid;
   assign bus.alu_decode  = s2_dec.op;
   assign bus.rs1_addr    = s2_dec.rs1;
   assign bus.rs2_addr    = s2_dec.rs2;
   assign bus.rd_addr     = s2_dec.rd;
   assign bus.imm_sel     = s2_dec.imm_sel;
   assign bus.illegal     = s2_dec.illegal;
   assign bus.illegal_cnt = cnt;
`ifdef ALU_DEC_IMM_EN
   assign bus.imm         = s2_imm;
`else
   assign bus.imm         = '0;
`endif
endmodule
